input_port: RTL and testbench

Router input unit. Accepts flits from the upstream link and steers each into a per-VC `fifo` instance selected by the flit's VC id. Runs a per-VC state machine: IDLE, then waiting for VC allocation, then active until the tail leaves. Issues VC-allocation and switch-allocation requests, pops granted flits into a registered output stage, and returns one credit upstream per freed buffer slot.

---
 rtl/input_port.sv | 196 +++++++++++++++++++
 tb/tb_input_port.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_port.sv
// Router input unit: per-VC flit buffering, VC/switch allocation requests,
// a registered output stage and upstream credit return.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] indata_i,
  output logic [WIDTH-1:0] outdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rdPtr_q, wrPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  // A push always wins: a pop requested in the same cycle is silently lost.
  assign doPush    = push_i && !full_o;
  assign doPop     = pop_i && !empty_o && !push_i;
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign outdata_o = mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= indata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (doPush) begin
      wrPtr_q <= (wrPtr_q == AW'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
      count_q <= count_q + 1'b1;
    end else if (doPop) begin
      rdPtr_q <= (rdPtr_q == AW'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
      count_q <= count_q - 1'b1;
    end
  end
endmodule

module input_port #(
  parameter int NUM_VC     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = `FLIT_DATA_WIDTH,
  parameter int VCW        = $clog2(NUM_VC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [VCW-1:0]        in_vc,
  input  logic [1:0]            in_type,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [NUM_VC-1:0]     va_req,
  input  logic [NUM_VC-1:0]     va_grant,
  output logic [NUM_VC-1:0]     sa_req,
  input  logic [NUM_VC-1:0]     sa_grant,
  output logic                  out_valid,
  output logic [VCW-1:0]        out_vc,
  output logic [1:0]            out_type,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  credit_valid,
  output logic [VCW-1:0]        credit_vc,
  output logic [NUM_VC-1:0]     vc_empty,
  output logic                  overflow_err,
  output logic                  proto_err
);
  localparam int FW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, WAIT_VA, ACTIVE} vcState_t;

  vcState_t              state_q [NUM_VC];
  logic [FW-1:0]         front [NUM_VC];
  logic [1:0]            frontType [NUM_VC];
  logic [NUM_VC-1:0]     full, empty, colMask, vaReq, saReq, discCand, popVec;
  logic                  grantValid, discValid, overflow;
  logic [VCW-1:0]        grantVc, discVc;

  logic                  outValid_q, creditValid_q, overflowErr_q, protoErr_q;
  logic [VCW-1:0]        outVc_q, creditVc_q;
  logic [1:0]            outType_q;
  logic [DATA_WIDTH-1:0] outData_q;

  for (genvar g = 0; g < NUM_VC; g++) begin : gVc
    fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) uFifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (colMask[g]),
      .pop_i     (popVec[g]),
      .indata_i  ({in_type, in_data}),
      .outdata_o (front[g]),
      .full_o    (full[g]),
      .empty_o   (empty[g])
    );
    assign frontType[g] = front[g][FW-1 -: 2];
  end

  // A VC receiving a push this cycle must not pop, or the fifo would drop the pop.
  always_comb begin
    colMask  = '0;
    vaReq    = '0;
    saReq    = '0;
    discCand = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      colMask[v]  = in_valid && (in_vc == VCW'(v));
      vaReq[v]    = (state_q[v] == WAIT_VA);
      saReq[v]    = (state_q[v] == ACTIVE) && !empty[v] && !colMask[v];
      discCand[v] = (state_q[v] == IDLE) && !empty[v] && !colMask[v] &&
                    (frontType[v][1] != frontType[v][0]);
    end
  end

  always_comb begin
    grantValid = 1'b0;
    grantVc    = '0;
    discValid  = 1'b0;
    discVc     = '0;
    popVec     = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (sa_grant[v] && saReq[v]) begin
        grantValid = 1'b1;
        grantVc    = VCW'(v);
      end
      if (discCand[v]) begin
        discValid = 1'b1;
        discVc    = VCW'(v);
      end
    end
    if (grantValid) discValid = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      popVec[v] = (grantValid && grantVc == VCW'(v)) || (discValid && discVc == VCW'(v));
    end
  end

  assign overflow = |(colMask & full);

  // Per-VC FSMs plus the registered output, credit and error stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= IDLE;
      outValid_q    <= 1'b0;
      outVc_q       <= '0;
      outType_q     <= '0;
      outData_q     <= '0;
      creditValid_q <= 1'b0;
      creditVc_q    <= '0;
      overflowErr_q <= 1'b0;
      protoErr_q    <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        case (state_q[v])
          IDLE:    if (!empty[v] && frontType[v][1] == frontType[v][0]) state_q[v] <= WAIT_VA;
          WAIT_VA: if (va_grant[v]) state_q[v] <= ACTIVE;
          ACTIVE:  if (grantValid && grantVc == VCW'(v) && frontType[v][1]) state_q[v] <= IDLE;
          default: state_q[v] <= IDLE;
        endcase
      end
      outValid_q    <= grantValid;
      creditValid_q <= grantValid || discValid;
      if (grantValid) begin
        outVc_q    <= grantVc;
        outType_q  <= frontType[grantVc];
        outData_q  <= front[grantVc][DATA_WIDTH-1:0];
        creditVc_q <= grantVc;
      end else if (discValid) begin
        creditVc_q <= discVc;
      end
      if (overflow)  overflowErr_q <= 1'b1;
      if (discValid) protoErr_q    <= 1'b1;
    end
  end

  assign va_req       = vaReq;
  assign sa_req       = saReq;
  assign vc_empty     = empty;
  assign out_valid    = outValid_q;
  assign out_vc       = outVc_q;
  assign out_type     = outType_q;
  assign out_data     = outData_q;
  assign credit_valid = creditValid_q;
  assign credit_vc    = creditVc_q;
  assign overflow_err = overflowErr_q;
  assign proto_err    = protoErr_q;
endmodule

// File: tb/tb_input_port.sv
// Randomized and directed bench for input_port against a queue-based packet model.
module tb_input_port;
   localparam int NV = 4;
   localparam int DEPTH = 8;
   localparam int DW = 32;
   localparam int PH_IDLE = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_ACTIVE = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic inValid = 1'b0;
   logic [1:0] inVc = '0;
   logic [1:0] inType = '0;
   logic [DW-1:0] inData = '0;
   logic [NV-1:0] vaReq, vaGrant = '0, saReq, saGrant = '0, vcEmpty;
   logic outValid, creditValid, overflowErr, protoErr;
   logic [1:0] outVc, outType, creditVc;
   logic [DW-1:0] outData;

   int checks = 0;
   int errors = 0;

   // Reference model: one flit queue and one packet phase per VC, plus held outputs.
   logic [DW+1:0] mq [NV][$];
   int ph [NV];
   logic mOutValid, mCredV, mOvf, mProto;
   logic [1:0] mOutVc, mOutType, mCredVc;
   logic [DW-1:0] mOutData;

   input_port #(.NUM_VC(NV), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .VCW(2)) dut (
      .clk(clock), .reset(reset), .in_valid(inValid), .in_vc(inVc), .in_type(inType),
      .in_data(inData), .va_req(vaReq), .va_grant(vaGrant), .sa_req(saReq),
      .sa_grant(saGrant), .out_valid(outValid), .out_vc(outVc), .out_type(outType),
      .out_data(outData), .credit_valid(creditValid), .credit_vc(creditVc),
      .vc_empty(vcEmpty), .overflow_err(overflowErr), .proto_err(protoErr)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkRegistered();
      checkOutput("out_valid", outValid, mOutValid);
      checkOutput("out_vc", outVc, mOutVc);
      checkOutput("out_type", outType, mOutType);
      checkOutput("out_data", outData, mOutData);
      checkOutput("credit_valid", creditValid, mCredV);
      checkOutput("credit_vc", creditVc, mCredVc);
      checkOutput("overflow_err", overflowErr, mOvf);
      checkOutput("proto_err", protoErr, mProto);
   endtask

   // Reset flushes every queue; all registered outputs return to zero.
   task automatic resetDut();
      reset = 1'b1;
      inValid = 1'b0;
      vaGrant = '0;
      saGrant = '0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < NV; i++) begin
         mq[i].delete();
         ph[i] = PH_IDLE;
      end
      mOutValid = 0; mCredV = 0; mOvf = 0; mProto = 0;
      mOutVc = '0; mOutType = '0; mCredVc = '0; mOutData = '0;
      checkRegistered();
      checkOutput("reset_vc_empty", vcEmpty, 4'b1111);
      checkOutput("reset_va_req", vaReq, 4'b0000);
      checkOutput("reset_sa_req", saReq, 4'b0000);
   endtask

   // One clock cycle: drive inputs, check combinational requests, advance model, check registers.
   task automatic applyStimulus(input bit v, input int vc, input logic [1:0] typ, input bit vaTie,
                                input bit saTie, input logic [NV-1:0] saForce, input bit randGrant);
      logic [NV-1:0] expVa, expSa, expEmpty, col;
      logic [DW+1:0] fr, popped;
      logic [1:0] ft;
      int hon, disc;
      int nph [NV];
      inValid = v;
      inVc = 2'(vc);
      inType = typ;
      inData = $urandom();
      for (int i = 0; i < NV; i++) begin
         col[i] = v && (vc == i);
         expVa[i] = (ph[i] == PH_WAIT);
         expSa[i] = (ph[i] == PH_ACTIVE) && (mq[i].size() > 0) && !col[i];
         expEmpty[i] = (mq[i].size() == 0);
      end
      if (randGrant) begin
         vaGrant = 4'($urandom());
         saGrant = 4'($urandom());
      end else begin
         vaGrant = vaTie ? expVa : '0;
         saGrant = (saTie ? expSa : '0) | saForce;
      end
      #1;
      checkOutput("va_req", vaReq, expVa);
      checkOutput("sa_req", saReq, expSa);
      checkOutput("vc_empty", vcEmpty, expEmpty);

      hon = -1;
      for (int i = 0; i < NV; i++) if (hon < 0 && saGrant[i] && expSa[i]) hon = i;
      disc = -1;
      if (hon < 0) begin
         for (int i = 0; i < NV; i++) begin
            if (disc < 0 && ph[i] == PH_IDLE && mq[i].size() > 0 && !col[i]) begin
               fr = mq[i][0];
               ft = fr[DW+1:DW];
               if (ft == 2'b01 || ft == 2'b10) disc = i;
            end
         end
      end
      for (int i = 0; i < NV; i++) begin
         nph[i] = ph[i];
         if (ph[i] == PH_IDLE && mq[i].size() > 0) begin
            fr = mq[i][0];
            ft = fr[DW+1:DW];
            if (ft == 2'b00 || ft == 2'b11) nph[i] = PH_WAIT;
         end else if (ph[i] == PH_WAIT && vaGrant[i]) begin
            nph[i] = PH_ACTIVE;
         end else if (ph[i] == PH_ACTIVE && hon == i) begin
            fr = mq[i][0];
            ft = fr[DW+1:DW];
            if (ft == 2'b10 || ft == 2'b11) nph[i] = PH_IDLE;
         end
      end
      for (int i = 0; i < NV; i++) ph[i] = nph[i];

      mOutValid = 0;
      mCredV = 0;
      if (hon >= 0) begin
         popped = mq[hon].pop_front();
         mOutValid = 1;
         mOutVc = 2'(hon);
         mOutType = popped[DW+1:DW];
         mOutData = popped[DW-1:0];
         mCredV = 1;
         mCredVc = 2'(hon);
      end else if (disc >= 0) begin
         popped = mq[disc].pop_front();
         mCredV = 1;
         mCredVc = 2'(disc);
         mProto = 1;
      end
      if (v) begin
         if (mq[vc].size() == DEPTH) mOvf = 1;
         else mq[vc].push_back({typ, inData});
      end

      @(posedge clock);
      #1;
      inValid = 1'b0;
      checkRegistered();
   endtask

   task automatic idleCycles(input int n, input bit vaTie, input bit saTie);
      for (int k = 0; k < n; k++) applyStimulus(0, 0, 2'b00, vaTie, saTie, '0, 0);
   endtask

   initial begin
      // Single HEAD_TAIL on VC2 with grants tied to requests.
      resetDut();
      applyStimulus(1, 2, 2'b11, 1, 1, '0, 0);
      idleCycles(6, 1, 1);

      // Four-flit packet on VC0.
      resetDut();
      applyStimulus(1, 0, 2'b00, 1, 1, '0, 0);
      applyStimulus(1, 0, 2'b01, 1, 1, '0, 0);
      applyStimulus(1, 0, 2'b01, 1, 1, '0, 0);
      applyStimulus(1, 0, 2'b10, 1, 1, '0, 0);
      idleCycles(8, 1, 1);

      // Overfill VC1 without grants, then drain.
      resetDut();
      applyStimulus(1, 1, 2'b00, 0, 0, '0, 0);
      for (int k = 0; k < 8; k++) applyStimulus(1, 1, 2'b01, 0, 0, '0, 0);
      idleCycles(14, 1, 1);

      // Push to VC3 while sa_grant[3] is forced: the pop must be held off.
      resetDut();
      applyStimulus(1, 3, 2'b00, 1, 0, '0, 0);
      idleCycles(2, 1, 0);
      applyStimulus(1, 3, 2'b01, 1, 0, 4'b1000, 0);
      applyStimulus(1, 3, 2'b10, 1, 0, 4'b1000, 0);
      idleCycles(5, 1, 1);

      // BODY arriving on an idle VC is discarded.
      resetDut();
      applyStimulus(1, 0, 2'b01, 1, 1, '0, 0);
      idleCycles(3, 1, 1);

      // Reset while VC0 is active and holding flits.
      resetDut();
      applyStimulus(1, 0, 2'b00, 1, 0, '0, 0);
      applyStimulus(1, 0, 2'b01, 1, 0, '0, 0);
      applyStimulus(1, 0, 2'b01, 1, 0, '0, 0);
      idleCycles(2, 1, 0);
      resetDut();
      idleCycles(2, 1, 1);

      // Random traffic, mixing random and request-tied grants.
      resetDut();
      for (int k = 0; k < 600; k++) begin
         applyStimulus(($urandom_range(0, 3) != 0), int'($urandom_range(0, NV - 1)),
                       2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 2) != 0), '0, ($urandom_range(0, 3) == 0));
         if (k % 150 == 149) resetDut();
      end
      idleCycles(40, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
